keypad_entry_ctrl: RTL and testbench

Sequencing controller between the 3x4 keypad scanner and the 4-digit 7-segment display driver. It synchronises and debounces the scanner's key levels and turns each clean press into one key event. Events drive a small entry state machine: digits shift in, '*' deletes, '#' confirms. It drives the display's hexx/mask/points inputs and hands a confirmed 4-digit BCD value to downstream logic.

---
 rtl/keypad_entry_ctrl_pkg.sv | 17 +
 rtl/key_debounce.sv | 61 ++++++
 rtl/keypad_entry_ctrl.sv | 134 +++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_ctrl_pkg.sv
// keypad_ctrl_pkg: shared types and constants for the keypad entry controller.
//   state_t    : entry FSM states (IDLE, ENTRY, SHOW)
//   KEY_*      : key codes beyond the digits 0-9
//   KEY_W      : scanner key vector width {hash, asterisk, numbers}
//   NUM_DIGITS : display digit count
//   digit_mask : mask with the low n display digits enabled
package keypad_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ENTRY, SHOW} state_t;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd15;
    localparam int KEY_W = 12;
    localparam int NUM_DIGITS = 4;
    function automatic logic [3:0] digit_mask(input logic [2:0] n);
        return 4'((5'd1 << n) - 5'd1);
    endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronise and debounce a key level vector, emit one event per clean single-key press.
//   gclk, rst_n : clock, asynchronous active-low reset
//   keys        : raw scanner levels
//   key_evt     : one-cycle pulse on an accepted single-key press
//   key_code    : index of the pressed key while key_evt is high, else KEY_NONE
module key_debounce
    import keypad_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2048,
    parameter int WIDTH = 12
) (
    input  logic             gclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] keys,
    output logic             key_evt,
    output logic [3:0]       key_code
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [WIDTH-1:0] s1, s2, cand, acc;
    logic [CW-1:0] cnt;
    logic armed, stable;
    logic [3:0] enc;
    assign stable = (s2 == cand) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    always_comb begin
        enc = KEY_NONE;
        for (int i = 0; i < WIDTH; i++)
            if (cand[i]) enc = 4'(i);
    end
    // armed stays low until an all-released vector has been seen stable, so a
    // key held through reset release is absorbed without producing an event
    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            cand <= '0;
            acc <= '0;
            cnt <= '0;
            armed <= 1'b0;
            key_evt <= 1'b0;
            key_code <= KEY_NONE;
        end else begin
            s1 <= keys;
            s2 <= s1;
            key_evt <= 1'b0;
            key_code <= KEY_NONE;
            if (s2 != cand) begin
                cand <= s2;
                cnt <= '0;
            end else if (!stable) begin
                cnt <= cnt + 1'b1;
            end else if (cand != acc) begin
                acc <= cand;
                if (armed && acc == '0 && $onehot(cand)) begin
                    key_evt <= 1'b1;
                    key_code <= enc;
                end
            end
            if (stable && cand == '0 && s1 == '0) armed <= 1'b1;
        end
    end
endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: keypad digit entry FSM driving a 4-digit 7-segment display.
//   gclk, rst_n        : clock, asynchronous active-low reset
//   numbers/asterisk/hash : scanner key levels
//   hexx/mask/points   : display BCD nibbles, digit enables, decimal points
//   value/value_valid  : last confirmed BCD value and its one-cycle update pulse
// Optional: define KEYPAD_TIMEOUT_EN to auto-clear an idle entry after TIMEOUT_CYCLES.
module keypad_entry_ctrl
    import keypad_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2048,
    parameter int HOLD_CYCLES = 24000000,
    parameter int TIMEOUT_CYCLES = 240000000
) (
    input  logic        gclk,
    input  logic        rst_n,
    input  logic [9:0]  numbers,
    input  logic        asterisk,
    input  logic        hash,
    output logic [15:0] hexx,
    output logic [3:0]  mask,
    output logic [3:0]  points,
    output logic [15:0] value,
    output logic        value_valid
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    state_t state, state_nxt;
    logic [2:0] count, count_nxt;
    logic [15:0] hexx_nxt, value_nxt;
    logic [3:0] mask_nxt, points_nxt;
    logic vv_nxt, key_evt, is_dig, full;
    logic [3:0] key_code;
    logic [HW-1:0] hold, hold_nxt;
`ifdef KEYPAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt, to_nxt;
`endif
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WIDTH(KEY_W)) u_debounce (
        .gclk(gclk),
        .rst_n(rst_n),
        .keys({hash, asterisk, numbers}),
        .key_evt(key_evt),
        .key_code(key_code)
    );
    assign is_dig = key_code < 4'd10;
    assign full = count == 3'(NUM_DIGITS);
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        hexx_nxt = hexx;
        mask_nxt = mask;
        points_nxt = points;
        value_nxt = value;
        vv_nxt = 1'b0;
        hold_nxt = hold;
`ifdef KEYPAD_TIMEOUT_EN
        to_nxt = (state != ENTRY || key_evt) ? TW'(TIMEOUT_CYCLES - 1) : to_cnt - 1'b1;
`endif
        case (state)
            IDLE: begin
                if (key_evt && is_dig) begin
                    hexx_nxt = {12'h000, key_code};
                    count_nxt = 3'd1;
                    state_nxt = ENTRY;
                end
            end
            ENTRY: begin
                if (key_evt && is_dig && !full) begin
                    hexx_nxt = {hexx[11:0], key_code};
                    count_nxt = count + 3'd1;
                end else if (key_evt && key_code == KEY_STAR) begin
                    hexx_nxt = {4'h0, hexx[15:4]};
                    count_nxt = count - 3'd1;
                    state_nxt = (count == 3'd1) ? IDLE : ENTRY;
                end else if (key_evt && key_code == KEY_HASH) begin
                    value_nxt = hexx;
                    vv_nxt = 1'b1;
                    hold_nxt = HW'(HOLD_CYCLES - 1);
                    state_nxt = SHOW;
`ifdef KEYPAD_TIMEOUT_EN
                end else if (!key_evt && to_cnt == '0) begin
                    hexx_nxt = '0;
                    count_nxt = '0;
                    state_nxt = IDLE;
`endif
                end
            end
            SHOW: begin
                if (hold == '0) begin
                    hexx_nxt = '0;
                    count_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    hold_nxt = hold - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // mask and points follow the digit count outside SHOW; SHOW freezes the
        // mask and lights every point from the confirming cycle onward
        if (state_nxt != SHOW) begin
            mask_nxt = digit_mask(count_nxt);
            points_nxt = {3'b000, count_nxt == 3'(NUM_DIGITS)};
        end else if (state != SHOW) begin
            points_nxt = 4'hF;
        end
    end
    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            hexx <= '0;
            mask <= '0;
            points <= '0;
            value <= '0;
            value_valid <= 1'b0;
            hold <= '0;
`ifdef KEYPAD_TIMEOUT_EN
            to_cnt <= '0;
`endif
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            hexx <= hexx_nxt;
            mask <= mask_nxt;
            points <= points_nxt;
            value <= value_nxt;
            value_valid <= vv_nxt;
            hold <= hold_nxt;
`ifdef KEYPAD_TIMEOUT_EN
            to_cnt <= to_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: self-checking bench for keypad_entry_ctrl with a display-snapshot scoreboard.
module tb_keypad_entry_ctrl;
    localparam int DB = 4;
    localparam int HOLD = 16;
    localparam int TO = 64;
    logic gclk = 1'b0;
    logic rst_n = 1'b0;
    logic [11:0] kv = '0;
    logic [15:0] hexx, value;
    logic [3:0] mask, points;
    logic value_valid;
    logic [23:0] exp_q[$];
    logic [23:0] got, exp;
    int n_tests = 0;
    int n_fail = 0;
    int vv_cnt = 0;

    keypad_entry_ctrl #(.DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)) dut (
        .gclk(gclk),
        .rst_n(rst_n),
        .numbers(kv[9:0]),
        .asterisk(kv[10]),
        .hash(kv[11]),
        .hexx(hexx),
        .mask(mask),
        .points(points),
        .value(value),
        .value_valid(value_valid)
    );

    always #5 gclk = ~gclk;
    always @(negedge gclk) if (value_valid === 1'b1) vv_cnt++;

    task automatic tick(input int n);
        repeat (n) @(negedge gclk);
    endtask

    task automatic press(input int k);
        kv[k] = 1'b1;
        tick(DB + 6);
        kv[k] = 1'b0;
        tick(DB + 6);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        n_tests++;
        if ({hexx, mask, points, value, value_valid} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset outputs got %h %b %b %h %b exp all zero", hexx, mask, points, value, value_valid);
        end
        rst_n = 1'b1;
        tick(DB + 6);
        n_tests++;
        if ({hexx, mask, points, value_valid} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_release got %h %b %b %b exp all zero", hexx, mask, points, value_valid);
        end
    endtask

    task automatic test_confirm;
        int keys[3] = '{1, 2, 3};
        logic [23:0] exps[3] = '{{16'h0001, 4'b0001, 4'b0000}, {16'h0012, 4'b0011, 4'b0000},
                                 {16'h0123, 4'b0111, 4'b0000}};
        int t, n, v0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exps[i]);
            press(keys[i]);
            got = {hexx, mask, points};
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL confirm_digit%0d got %h exp %h", i, got, exp);
            end
        end
        v0 = vv_cnt;
        kv[11] = 1'b1;
        t = 0;
        while (value_valid !== 1'b1 && t < 30) begin
            tick(1);
            t++;
        end
        kv[11] = 1'b0;
        n_tests++;
        if (value_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL confirm_pulse got no value_valid exp pulse within 30 cycles");
        end
        n_tests++;
        if ({value, hexx, mask, points} !== {16'h0123, 16'h0123, 4'b0111, 4'b1111}) begin
            n_fail++;
            $display("FAIL confirm_show got value %h hexx %h mask %b points %b exp 0123 0123 0111 1111",
                     value, hexx, mask, points);
        end
        n = 0;
        while (points === 4'hF && n < 40) begin
            n++;
            tick(1);
        end
        n_tests++;
        if (n != HOLD) begin
            n_fail++;
            $display("FAIL show_duration got %0d exp %0d", n, HOLD);
        end
        n_tests++;
        if ({hexx, mask, points, value} !== {24'd0, 16'h0123}) begin
            n_fail++;
            $display("FAIL show_expire got %h %b %b value %h exp 0 0 0 value 0123", hexx, mask, points, value);
        end
        tick(5);
        n_tests++;
        if (vv_cnt - v0 != 1) begin
            n_fail++;
            $display("FAIL confirm_pulse_count got %0d exp 1", vv_cnt - v0);
        end
    endtask

    task automatic test_full_delete;
        int keys[9] = '{9, 8, 7, 6, 5, 10, 10, 10, 10};
        logic [23:0] exps[9] = '{{16'h0009, 4'b0001, 4'b0000}, {16'h0098, 4'b0011, 4'b0000},
                                 {16'h0987, 4'b0111, 4'b0000}, {16'h9876, 4'b1111, 4'b0001},
                                 {16'h9876, 4'b1111, 4'b0001}, {16'h0987, 4'b0111, 4'b0000},
                                 {16'h0098, 4'b0011, 4'b0000}, {16'h0009, 4'b0001, 4'b0000},
                                 {16'h0000, 4'b0000, 4'b0000}};
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(exps[i]);
            press(keys[i]);
            got = {hexx, mask, points};
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL full_delete_step%0d got %h exp %h", i, got, exp);
            end
        end
        press(10);
        n_tests++;
        if ({hexx, mask, points} !== 24'd0) begin
            n_fail++;
            $display("FAIL star_in_idle got %h exp 000000", {hexx, mask, points});
        end
    endtask

    task automatic test_bounce;
        for (int i = 0; i < 10; i++) begin
            kv[4] = (i % 2 == 0);
            tick(2);
        end
        exp_q.push_back({16'h0004, 4'b0001, 4'b0000});
        press(4);
        got = {hexx, mask, points};
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL bounce_single got %h exp %h", got, exp);
        end
        exp_q.push_back({16'h0004, 4'b0001, 4'b0000});
        kv[1] = 1'b1;
        tick(3);
        kv[1] = 1'b0;
        tick(DB + 6);
        got = {hexx, mask, points};
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL short_pulse got %h exp %h", got, exp);
        end
        press(10);
    endtask

    task automatic test_multi;
        logic [11:0] steps[4] = '{12'h024, 12'h004, 12'h000, 12'h000};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(24'd0);
            kv = steps[i];
            tick(DB + 6);
            got = {hexx, mask, points};
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL multi_step%0d got %h exp %h", i, got, exp);
            end
        end
        exp_q.push_back({16'h0002, 4'b0001, 4'b0000});
        press(2);
        got = {hexx, mask, points};
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL multi_fresh got %h exp %h", got, exp);
        end
        press(10);
    endtask

    task automatic test_reset_mid;
        exp_q.push_back({16'h0007, 4'b0001, 4'b0000});
        kv[7] = 1'b1;
        tick(DB + 6);
        got = {hexx, mask, points};
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_entry got %h exp %h", got, exp);
        end
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({hexx, mask, points, value_valid} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_async got %h %b %b %b exp all zero", hexx, mask, points, value_valid);
        end
        tick(3);
        rst_n = 1'b1;
        tick(DB + 10);
        n_tests++;
        if ({hexx, mask, points} !== 24'd0) begin
            n_fail++;
            $display("FAIL held_after_reset got %h exp 000000", {hexx, mask, points});
        end
        kv[7] = 1'b0;
        tick(DB + 6);
        n_tests++;
        if ({hexx, mask, points} !== 24'd0) begin
            n_fail++;
            $display("FAIL release_after_reset got %h exp 000000", {hexx, mask, points});
        end
        exp_q.push_back({16'h0006, 4'b0001, 4'b0000});
        press(6);
        got = {hexx, mask, points};
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL rearm_after_reset got %h exp %h", got, exp);
        end
        press(10);
    endtask

    task automatic test_timeout;
        int v0;
        v0 = vv_cnt;
        exp_q.push_back({16'h0003, 4'b0001, 4'b0000});
        press(3);
        got = {hexx, mask, points};
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL timeout_entry got %h exp %h", got, exp);
        end
        tick(TO);
`ifdef KEYPAD_TIMEOUT_EN
        exp_q.push_back(24'd0);
`else
        exp_q.push_back({16'h0003, 4'b0001, 4'b0000});
`endif
        got = {hexx, mask, points};
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL timeout_idle got %h exp %h", got, exp);
        end
        n_tests++;
        if (vv_cnt != v0) begin
            n_fail++;
            $display("FAIL timeout_no_pulse got %0d pulses exp 0", vv_cnt - v0);
        end
`ifndef KEYPAD_TIMEOUT_EN
        press(10);
`endif
    endtask

    initial begin
        test_reset;
        test_confirm;
        test_full_delete;
        test_bounce;
        test_multi;
        test_reset_mid;
        test_timeout;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
